// File: rtl/conv_layer_ctrl.sv
// Sequences a convolution layer one output channel at a time.
// Each channel: fetch its kernel, load it into the core, let the core settle, then hand off the feature map.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | weight ROM read for current channel
// LOAD  | capture ROM word into core_weights
// EVAL  | core settling, SETTLE cycles
// EMIT  | feature map offered downstream
// DONE  | one-cycle completion pulse
module conv_layer_ctrl #(
    parameter int IC           = 8,
    parameter int OC           = 16,
    parameter int IMG_OUT_SIZE = 28,
    parameter int SETTLE       = 2,
    localparam int CW          = (OC > 1) ? $clog2(OC) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 wt_rd_en,
    output logic [CW-1:0]                        wt_addr,
    input  logic [IC*9-1:0]                      wt_rdata,
    output logic [IC*9-1:0]                      core_weights,
    input  logic [IMG_OUT_SIZE*IMG_OUT_SIZE-1:0] core_img_out,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [IMG_OUT_SIZE*IMG_OUT_SIZE-1:0] out_data,
    output logic [CW-1:0]                        out_ch
);
    localparam int KW = IC * 9;
    localparam int PW = IMG_OUT_SIZE * IMG_OUT_SIZE;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_EVAL  = 3'd3;
    localparam logic [2:0] S_EMIT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] ch_q, ch_d;
    logic [3:0]    settle_q, settle_d;
    logic [KW-1:0] core_weights_q, core_weights_d;
    logic [PW-1:0] out_data_q, out_data_d;
    logic [CW-1:0] out_ch_q, out_ch_d;

    always_comb begin
        state_d        = state_q;
        ch_d           = ch_q;
        settle_d       = settle_q;
        core_weights_d = core_weights_q;
        out_data_d     = out_data_q;
        out_ch_d       = out_ch_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ch_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                core_weights_d = wt_rdata;
                settle_d       = '0;
                state_d        = S_EVAL;
            end
            S_EVAL: begin
                // Snapshot on the last settle cycle so the core has had SETTLE full cycles.
                if (settle_q == 4'(SETTLE - 1)) begin
                    out_data_d = core_img_out;
                    out_ch_d   = ch_q;
                    state_d    = S_EMIT;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (ch_q == CW'(OC - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        ch_d    = ch_q + CW'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            ch_q           <= '0;
            settle_q       <= '0;
            core_weights_q <= '0;
            out_data_q     <= '0;
            out_ch_q       <= '0;
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            settle_q       <= settle_d;
            core_weights_q <= core_weights_d;
            out_data_q     <= out_data_d;
            out_ch_q       <= out_ch_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign wt_rd_en     = (state_q == S_FETCH);
    assign wt_addr      = ch_q;
    assign out_valid    = (state_q == S_EMIT);
    assign core_weights = core_weights_q;
    assign out_data     = out_data_q;
    assign out_ch       = out_ch_q;

endmodule

// File: doc/conv_layer_ctrl.md
CONV_LAYER_CTRL -- requirements
Module: conv_layer_ctrl

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning): IC, 8, input channels per kernel; OC, 16, output channels to sequence; IMG_OUT_SIZE, 28, core output edge length; SETTLE, 2, evaluation cycles allowed for core combinational settling (range 1..15).
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows (name, direction, width, meaning): clk, in, 1, rising-edge clock; rst_n, in, 1, asynchronous active-low reset.
REQ-003 Port start, in, 1: request one full layer pass; sampled only in IDLE.
REQ-004 Port busy, out, 1: high in every state except IDLE.
REQ-005 Port done, out, 1: one-cycle pulse when the last channel has been accepted.
REQ-006 Port wt_rd_en, out, 1: weight ROM read strobe.
REQ-007 Port wt_addr, out, CW=max(1,$clog2(OC)): weight ROM address, equal to the current channel.
REQ-008 Port wt_rdata, in, IC*9: ROM data, valid exactly one cycle after wt_rd_en.
REQ-009 Port core_weights, out, IC*9: registered kernel driven to the convolution core.
REQ-010 Port core_img_out, in, IMG_OUT_SIZE*IMG_OUT_SIZE: core result bitmap.
REQ-011 Port out_valid, out, 1; out_ready, in, 1; out_data, out, IMG_OUT_SIZE*IMG_OUT_SIZE; out_ch, out, CW: downstream per-channel feature map handshake.

Function
REQ-012 FSM states SHALL be IDLE, FETCH, LOAD, EVAL, EMIT and DONE.
REQ-013 IDLE: if start=1, the FSM SHALL clear ch to 0 and go to FETCH; otherwise it SHALL hold.
REQ-014 FETCH (1 cycle): wt_rd_en=1 and wt_addr=ch; the next state SHALL be LOAD.
REQ-015 LOAD (1 cycle): core_weights SHALL be loaded with wt_rdata; settle counter SHALL be cleared; the next state SHALL be EVAL.
REQ-016 EVAL (exactly SETTLE cycles): on the last EVAL cycle, out_data SHALL be loaded with core_img_out and out_ch with ch, then the next state SHALL be EMIT.
REQ-017 EMIT: out_valid=1; out_data and out_ch SHALL hold stable until out_valid&&out_ready.
REQ-018 On handshake in EMIT: if ch==OC-1, the next state SHALL be DONE; else ch SHALL increment and the next state SHALL be FETCH.
REQ-019 DONE (1 cycle): done=1, busy=1; the next state SHALL be IDLE.
REQ-020 wt_rd_en SHALL be 0 outside FETCH; out_valid SHALL be 0 outside EMIT; done SHALL be 0 outside DONE.
REQ-021 start while busy SHALL be ignored; no queuing.
REQ-022 start in the DONE cycle SHALL be ignored; start in IDLE on the next cycle SHALL be honoured.
REQ-023 Per-channel latency with out_ready held at 1 SHALL be SETTLE+3 cycles; the full pass SHALL take OC*(SETTLE+3)+1 cycles from the cycle after start to done inclusive.
REQ-024 Backpressure (out_ready=0) SHALL stall only in EMIT, with no channel skipped or repeated.
REQ-025 ch SHALL never exceed OC-1; no wrap-around to 0 inside a pass.
REQ-026 core_weights SHALL change only in LOAD, so the core input is stable throughout EVAL and EMIT.
REQ-027 Upstream SHALL hold the core image input stable while busy=1; the block SHALL not check this.

Reset
REQ-028 On rst_n=0, asynchronously: state=IDLE, ch=0, settle=0, busy=0, done=0, wt_rd_en=0, wt_addr=0, core_weights=0, out_valid=0, out_data=0, out_ch=0.
REQ-029 Reset asserted mid-pass SHALL abort the pass with no done pulse; after release, the block SHALL wait in IDLE for a new start.

Verification
REQ-030 OC=16, SETTLE=2, out_ready=1, start at cycle 0 -> wt_rd_en at cycle 1; out_valid at cycles 5,10,...,80 with out_ch=0..15; done at cycle 81; busy=0 at cycle 82.
REQ-031 ROM word k=k-th pattern and core model = registered weights copied into out_data -> each out_data matches the ROM word for its out_ch.
REQ-032 out_ready=0 for 7 cycles during channel 3 EMIT -> out_valid held, out_data/out_ch stable, done delayed by exactly 7 cycles, no channel lost.
REQ-033 start pulsed during EVAL and during DONE -> ignored; exactly one done; a start one cycle after DONE begins a fresh pass at ch=0.
REQ-034 rst_n low during channel 6 EVAL -> all outputs at reset values immediately, no done; a subsequent start yields a full 16-channel pass.
REQ-035 OC=1, SETTLE=1 -> single out_valid at cycle 4 and done at cycle 5; wt_addr width 1.
